// File: rtl/ser_pkg.sv
// Shared types and constants for the PISO serializer.
// The optional parity beat is enabled by defining SER_PARITY_EN.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_e;

  localparam logic        SER_IDLE_READY = 1'b1;
  localparam int unsigned SER_PAR_SEL    = '0;

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable up/down bit-index counter. is_end flags the final data index
// for the configured direction (WIDTH-1 counting up, 0 counting down).
module ser_bit_counter #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEL_W-1:0] start,
  input  logic             dir,
  input  logic             en,
  output logic [SEL_W-1:0] count,
  output logic             is_end
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WIDTH - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (load) count <= start;
    else if (en)   count <= dir ? count - 1'b1 : count + 1'b1;
  end

  assign is_end = dir ? (count == '0) : (count == LAST_IDX);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready on both sides and zero-bubble reload.
// Define SER_PARITY_EN to append an even-parity beat after the data bits.
module piso_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_W     = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [SEL_W-1:0] out_sel,
  output logic             busy
);

  localparam logic [SEL_W-1:0] START_IDX = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;

  ser_state_e       r_state;
  ser_state_e       w_next;
  logic [WIDTH-1:0] r_word;
  logic [SEL_W-1:0] w_idx;
  logic             w_is_end;
  logic             w_word_done;
  logic             w_load;
  logic             w_adv;

`ifdef SER_PARITY_EN
  logic r_par;
  assign w_word_done = (r_state == PAR) && out_ready;
`else
  assign w_word_done = (r_state == SHIFT) && w_is_end && out_ready;
`endif

  // Ready is also raised on the final handshake so the next word loads without a bubble.
  assign in_ready = (r_state == IDLE) ? SER_IDLE_READY : w_word_done;
  assign w_load   = in_valid && in_ready;
  assign w_adv    = (r_state == SHIFT) && out_ready && !w_is_end;

  ser_bit_counter #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .start  (START_IDX),
    .dir    (MSB_FIRST),
    .en     (w_adv),
    .count  (w_idx),
    .is_end (w_is_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: the word register has no reset; out_bit is gated by state, so stale contents never reach the port.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_word <= in_data;
`ifdef SER_PARITY_EN
      r_par  <= ^in_data;
`endif
    end
  end

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    out_sel   = '0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_load) w_next = SHIFT;
      end
      SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_bit   = r_word[w_idx];
        out_sel   = w_idx;
`ifdef SER_PARITY_EN
        if (out_ready && w_is_end) w_next = PAR;
`else
        out_last  = w_is_end;
        if (out_ready && w_is_end) w_next = w_load ? SHIFT : IDLE;
`endif
      end
`ifdef SER_PARITY_EN
      PAR: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_bit   = r_par;
        out_sel   = SEL_W'(SER_PAR_SEL);
        out_last  = 1'b1;
        if (out_ready) w_next = w_load ? SHIFT : IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first and MSB-first instances, backpressure,
// back-to-back reload, mid-word reset, and the parity beat when SER_PARITY_EN is defined.
module tb_piso_serializer;

`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [2:0] out_sel;
  logic       busy;

  logic [7:0] m_in_data;
  logic       m_in_valid;
  logic       m_in_ready;
  logic       m_out_bit;
  logic       m_out_valid;
  logic       m_out_ready;
  logic       m_out_last;
  logic [2:0] m_out_sel;
  logic       m_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  piso_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .busy      (busy)
  );

  piso_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk       (clk),
    .rst       (rst),
    .in_data   (m_in_data),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .out_bit   (m_out_bit),
    .out_valid (m_out_valid),
    .out_ready (m_out_ready),
    .out_last  (m_out_last),
    .out_sel   (m_out_sel),
    .busy      (m_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one accepted beat on the LSB-first instance, then advances one cycle.
  task automatic beat(input string tag, input int n, input int sel, input logic b,
                      input logic last, input logic rdy);
    check($sformatf("%s_b%0d_valid", tag, n), 32'(out_valid), 32'd1);
    check($sformatf("%s_b%0d_busy",  tag, n), 32'(busy),      32'd1);
    check($sformatf("%s_b%0d_sel",   tag, n), 32'(out_sel),   32'(sel));
    check($sformatf("%s_b%0d_bit",   tag, n), 32'(out_bit),   32'(b));
    check($sformatf("%s_b%0d_last",  tag, n), 32'(out_last),  32'(last));
    check($sformatf("%s_b%0d_rdy",   tag, n), 32'(in_ready),  32'(rdy));
    tick();
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_busy"},  32'(busy),      32'd0);
    check({tag, "_idle_rdy"},   32'(in_ready),  32'd1);
  endtask

  initial begin
    logic [7:0] pat;
    rst         = 1'b1;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    m_in_data   = '0;
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_bit",   32'(out_bit),   32'd0);
    check("rst_sel",   32'(out_sel),   32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    rst = 1'b0;
    check("rst_rel_rdy", 32'(in_ready), 32'd1);
    tick();

    // 8'hA5, LSB first, no backpressure: 1,0,1,0,0,1,0,1
    pat       = 8'hA5;
    out_ready = 1'b1;
    in_data   = pat;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++)
      beat("a5", i, i, pat[i], (i == 7) && !PAR_EN, (i == 7) && !PAR_EN);
`ifdef SER_PARITY_EN
    beat("a5_par", 8, 0, 1'b0, 1'b1, 1'b1);
`endif
    idle_check("a5");

    // 8'hA5 with out_ready low for 3 cycles while bit 2 is presented
    in_data  = pat;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("bp", 0, 0, 1'b1, 1'b0, 1'b0);
    beat("bp", 1, 1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold%0d_sel",   k), 32'(out_sel),   32'd2);
      check($sformatf("bp_hold%0d_bit",   k), 32'(out_bit),   32'd1);
      check($sformatf("bp_hold%0d_last",  k), 32'(out_last),  32'd0);
      check($sformatf("bp_hold%0d_rdy",   k), 32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    beat("bp", 2, 2, 1'b1, 1'b0, 1'b0);
    beat("bp", 3, 3, 1'b0, 1'b0, 1'b0);
    beat("bp", 4, 4, 1'b0, 1'b0, 1'b0);
    beat("bp", 5, 5, 1'b1, 1'b0, 1'b0);
    beat("bp", 6, 6, 1'b0, 1'b0, 1'b0);
    beat("bp", 7, 7, 1'b1, !PAR_EN, !PAR_EN);
`ifdef SER_PARITY_EN
    beat("bp_par", 8, 0, 1'b0, 1'b1, 1'b1);
`endif
    idle_check("bp");

    // 8'hFF then 8'h00 back-to-back; 8'h00 is presented while FF is in flight
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_data = 8'h00;
    for (int i = 0; i < 8; i++)
      beat("ff", i, i, 1'b1, (i == 7) && !PAR_EN, (i == 7) && !PAR_EN);
`ifdef SER_PARITY_EN
    beat("ff_par", 8, 0, 1'b0, 1'b1, 1'b1);
`endif
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++)
      beat("zz", i, i, 1'b0, (i == 7) && !PAR_EN, (i == 7) && !PAR_EN);
`ifdef SER_PARITY_EN
    beat("zz_par", 8, 0, 1'b0, 1'b1, 1'b1);
`endif
    idle_check("zz");

    // 8'h3C interrupted by reset during beat 4; in_valid during reset is ignored
    in_data  = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("rs", 0, 0, 1'b0, 1'b0, 1'b0);
    beat("rs", 1, 1, 1'b0, 1'b0, 1'b0);
    beat("rs", 2, 2, 1'b1, 1'b0, 1'b0);
    check("rs_b3_sel", 32'(out_sel), 32'd3);
    check("rs_b3_bit", 32'(out_bit), 32'd1);
    rst = 1'b1;
    #1;
    check("rs_async_valid", 32'(out_valid), 32'd0);
    check("rs_async_busy",  32'(busy),      32'd0);
    check("rs_async_sel",   32'(out_sel),   32'd0);
    check("rs_async_last",  32'(out_last),  32'd0);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst      = 1'b0;
    check("rs_win_valid", 32'(out_valid), 32'd0);
    check("rs_rel_rdy",   32'(in_ready),  32'd1);
    in_data  = 8'h01;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("w01", 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++)
      beat("w01", i, i, 1'b0, (i == 7) && !PAR_EN, (i == 7) && !PAR_EN);
`ifdef SER_PARITY_EN
    beat("w01_par", 8, 0, 1'b1, 1'b1, 1'b1);
`endif
    idle_check("w01");

    // MSB-first instance, 8'h80: first beat 1 at sel 7, then zeros down to sel 0
    m_in_data  = 8'h80;
    m_in_valid = 1'b1;
    tick();
    m_in_valid = 1'b0;
    check("msb_b0_valid", 32'(m_out_valid), 32'd1);
    check("msb_b0_sel",   32'(m_out_sel),   32'd7);
    check("msb_b0_bit",   32'(m_out_bit),   32'd1);
    check("msb_b0_last",  32'(m_out_last),  32'd0);
    tick();
    for (int s = 6; s >= 0; s--) begin
      check($sformatf("msb_s%0d_valid", s), 32'(m_out_valid), 32'd1);
      check($sformatf("msb_s%0d_sel",   s), 32'(m_out_sel),   32'(s));
      check($sformatf("msb_s%0d_bit",   s), 32'(m_out_bit),   32'd0);
      check($sformatf("msb_s%0d_last",  s), 32'(m_out_last),  32'((s == 0) && !PAR_EN));
      tick();
    end
`ifdef SER_PARITY_EN
    check("msb_par_sel",  32'(m_out_sel),  32'd0);
    check("msb_par_bit",  32'(m_out_bit),  32'd1);
    check("msb_par_last", 32'(m_out_last), 32'd1);
    tick();
`endif
    check("msb_idle_valid", 32'(m_out_valid), 32'd0);
    check("msb_idle_rdy",   32'(m_in_ready),  32'd1);

`ifdef SER_PARITY_EN
    // Parity beat: 8'h07 -> 1, 8'h03 -> 0
    in_data  = 8'h07;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++)
      beat("p07", i, i, 1'(i < 3), 1'b0, 1'b0);
    beat("p07_par", 8, 0, 1'b1, 1'b1, 1'b1);
    idle_check("p07");
    in_data  = 8'h03;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++)
      beat("p03", i, i, 1'(i < 2), 1'b0, 1'b0);
    beat("p03_par", 8, 0, 1'b0, 1'b1, 1'b1);
    idle_check("p03");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
